// File: rtl/temp_mon_pkg.sv
// -----------------------------------------------------------------------------
// temp_mon_pkg
// Shared types and constants for the temperature-monitoring scan controller.
//   state_e   : scan controller FSM states
//   result_t  : bundle of published results (sum, count, average, flags)
//   TEMP_W    : width of one sensor reading
//   SUM_W     : width of the temperature accumulator / divider operands
//   CNT_W     : width of the enabled-sensor counter and of the sensor index
//   DEF_TEMP_LOW / DEF_TEMP_HIGH : default alert thresholds in degrees C
// -----------------------------------------------------------------------------
package temp_mon_pkg;

    localparam int TEMP_W = 8;
    localparam int SUM_W  = 16;
    localparam int CNT_W  = 8;

    localparam logic [TEMP_W-1:0] DEF_TEMP_LOW  = 8'd19;
    localparam logic [TEMP_W-1:0] DEF_TEMP_HIGH = 8'd26;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DIVIDE,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [SUM_W-1:0]  sum;
        logic [CNT_W-1:0]  cnt;
        logic [TEMP_W-1:0] avg;
        logic              err;
        logic              low;
        logic              high;
    } result_t;

endpackage

// File: rtl/temp_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// temp_scan_ctrl_if
// Request, sensor-bus and result signals of the scan controller.
//   start_i             : scan request (sampled only while idle)
//   sensors_en_i        : per-sensor enable, captured when a scan is accepted
//   sensor_data_i       : reading of the sensor addressed by sel_o
//   sel_o               : sensor index driven onto the sensor bus
//   busy_o / done_o     : scan in progress / one-cycle results-valid pulse
//   temp_sum_o, nr_active_sensors_o, temp_avg_o, err_o, temp_low_o,
//   temp_high_o         : published results of the last completed scan
// Modports: master = requester and sensor bank side, slave = controller.
// -----------------------------------------------------------------------------
interface temp_scan_ctrl_if
    import temp_mon_pkg::*;
#(
    parameter int NR_SENSORS = 200
);
    logic                  start_i;
    logic [NR_SENSORS-1:0] sensors_en_i;
    logic [TEMP_W-1:0]     sensor_data_i;
    logic [CNT_W-1:0]      sel_o;
    logic                  busy_o;
    logic                  done_o;
    logic [SUM_W-1:0]      temp_sum_o;
    logic [CNT_W-1:0]      nr_active_sensors_o;
    logic [TEMP_W-1:0]     temp_avg_o;
    logic                  err_o;
    logic                  temp_low_o;
    logic                  temp_high_o;

    modport master (
        output start_i, sensors_en_i, sensor_data_i,
        input  sel_o, busy_o, done_o, temp_sum_o, nr_active_sensors_o,
               temp_avg_o, err_o, temp_low_o, temp_high_o
    );

    modport slave (
        input  start_i, sensors_en_i, sensor_data_i,
        output sel_o, busy_o, done_o, temp_sum_o, nr_active_sensors_o,
               temp_avg_o, err_o, temp_low_o, temp_high_o
    );
endinterface

// File: rtl/temp_div_seq.sv
// -----------------------------------------------------------------------------
// temp_div_seq
// Sequential restoring divider, one quotient bit per clock, SUM_W iterations.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   start_i        : one-cycle pulse; operands are taken from dividend_i and
//                    divisor_i in that cycle
//   dividend_i     : SUM_W-bit dividend
//   divisor_i      : SUM_W-bit divisor (must be non-zero)
//   done_o         : one-cycle pulse, quotient_o valid in that cycle
//   quotient_o     : low TEMP_W bits of the quotient
// The start edge already performs the first iteration, so done_o rises
// SUM_W-1 cycles after the start cycle.
// -----------------------------------------------------------------------------
module temp_div_seq
    import temp_mon_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [SUM_W-1:0]  dividend_i,
    input  logic [SUM_W-1:0]  divisor_i,
    output logic              done_o,
    output logic [TEMP_W-1:0] quotient_o
);
    localparam logic [3:0] LAST_ITER = 4'(SUM_W - 1);

    logic [SUM_W-1:0] rem_q, quo_q, dsr_q;
    logic [3:0]       iter_q;
    logic             run_q, done_q;

    logic [SUM_W-1:0] rem_in, quo_in, dsr_in;
    logic [SUM_W:0]   shifted;
    logic [SUM_W-1:0] rem_d, quo_d;

    // One restoring step; on start it works straight on the fresh operands.
    always_comb begin
        // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
        rem_in  = start_i ? '0 : rem_q;
        quo_in  = start_i ? dividend_i : quo_q;
        dsr_in  = start_i ? divisor_i : dsr_q;
        shifted = {rem_in, quo_in[SUM_W-1]};
        rem_d   = shifted[SUM_W-1:0];
        quo_d   = {quo_in[SUM_W-2:0], 1'b0};
        if (shifted >= {1'b0, dsr_in}) begin
            rem_d    = SUM_W'(shifted - {1'b0, dsr_in});
            quo_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            iter_q <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            done_q <= 1'b0;
            if (start_i) begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                dsr_q  <= dsr_in;
                iter_q <= 4'd1;
                run_q  <= 1'b1;
            end else if (run_q) begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                iter_q <= iter_q + 4'd1;
                if (iter_q == LAST_ITER) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    // The average of 8-bit readings never exceeds 255, so the low byte is exact.
    assign quotient_o = quo_q[TEMP_W-1:0];

endmodule

// File: rtl/temp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// temp_scan_ctrl
// Scans NR_SENSORS sensors over a shared 8-bit bus, one per clock, sums the
// enabled readings, divides by their count and publishes registered results
// with a one-cycle done pulse.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   bus (slave)    : start/enable/data in, sel/busy/done/results out
// Build option TEMP_ALERT_EN: when defined, temp_low_o/temp_high_o compare the
// average against TEMP_LOW/TEMP_HIGH; otherwise both flags are constant 0 and
// the threshold parameters do not exist.
// -----------------------------------------------------------------------------
module temp_scan_ctrl
    import temp_mon_pkg::*;
#(
    parameter int NR_SENSORS = 200
`ifdef TEMP_ALERT_EN
    ,
    parameter logic [TEMP_W-1:0] TEMP_LOW  = DEF_TEMP_LOW,
    parameter logic [TEMP_W-1:0] TEMP_HIGH = DEF_TEMP_HIGH
`endif
) (
    input logic             clk_i,
    input logic             rst_n_i,
    temp_scan_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NR_SENSORS - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      idx_q, idx_d;
    logic [NR_SENSORS-1:0] en_q, en_d;
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    result_t               res_q, res_d;

    logic [SUM_W-1:0]      acc_sum;
    logic [CNT_W-1:0]      acc_cnt;
    logic                  div_start, div_done;
    logic [TEMP_W-1:0]     div_quot;
    logic                  alert_low, alert_high;

    // Divider is started in the last SCAN cycle with the final sum/count.
    temp_div_seq u_div (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .start_i    (div_start),
        .dividend_i (sum_d),
        .divisor_i  (SUM_W'(cnt_d)),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );

`ifdef TEMP_ALERT_EN
    assign alert_low  = (div_quot < TEMP_LOW);
    assign alert_high = (div_quot > TEMP_HIGH);
`else
    assign alert_low  = 1'b0;
    assign alert_high = 1'b0;
`endif

    // The snapshot shifts right each SCAN cycle, so bit 0 always belongs to
    // the sensor currently on the bus.
    assign acc_sum = sum_q + (en_q[0] ? SUM_W'(bus.sensor_data_i) : '0);
    assign acc_cnt = cnt_q + (en_q[0] ? CNT_W'(1) : '0);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        en_d      = en_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    en_d    = bus.sensors_en_i;
                    sum_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                sum_d = acc_sum;
                cnt_d = acc_cnt;
                en_d  = en_q >> 1;
                idx_d = idx_q + CNT_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (acc_cnt != '0) begin
                        state_d   = ST_DIVIDE;
                        div_start = 1'b1;
                    end else begin
                        state_d    = ST_DONE;
                        res_d      = '0;
                        res_d.sum  = acc_sum;
                        res_d.cnt  = acc_cnt;
                        res_d.err  = 1'b1;
                    end
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    state_d    = ST_DONE;
                    res_d.sum  = sum_q;
                    res_d.cnt  = cnt_q;
                    res_d.avg  = div_quot;
                    res_d.err  = 1'b0;
                    res_d.low  = alert_low;
                    res_d.high = alert_high;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            en_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign bus.sel_o               = idx_q;
    assign bus.busy_o              = (state_q != ST_IDLE);
    assign bus.done_o              = (state_q == ST_DONE);
    assign bus.temp_sum_o          = res_q.sum;
    assign bus.nr_active_sensors_o = res_q.cnt;
    assign bus.temp_avg_o          = res_q.avg;
    assign bus.err_o               = res_q.err;
    assign bus.temp_low_o          = res_q.low;
    assign bus.temp_high_o         = res_q.high;

endmodule
